// File: rtl/vacc_sched_pkg.sv
// Shared definitions for the vector-accumulator sequencer: FSM encoding and overrun limits.
// The optional watchdog in vacc_sched is enabled by defining VACC_SCHED_TIMEOUT_EN.
package vacc_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WAIT  = 2'd1;
  localparam state_t ST_ACCUM = 2'd2;
  localparam state_t ST_DUMP  = 2'd3;

  localparam int OVR_WIDTH = 16;
  localparam logic [OVR_WIDTH-1:0] OVR_MAX = 16'hFFFF;

  // Saturating increment for the overrun counter.
  function automatic logic [OVR_WIDTH-1:0] ovr_inc(input logic [OVR_WIDTH-1:0] cnt);
    if (cnt == OVR_MAX) begin
      ovr_inc = cnt;
    end else begin
      ovr_inc = cnt + 16'd1;
    end
  endfunction

endpackage

// File: rtl/vacc_dump_monitor.sv
// Watches the accumulator readout strobe: edge detection plus a count of strobe-high cycles.
// Part of vacc_sched (optional watchdog macro VACC_SCHED_TIMEOUT_EN does not affect this block).
module vacc_dump_monitor
  import vacc_sched_pkg::*;
#(
  parameter int VECTOR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  vacc_we,
  output logic                  rise,
  output logic                  fall,
  output logic [VECTOR_WIDTH:0] words
);

  localparam logic [VECTOR_WIDTH:0] WORDS_ONE = {{VECTOR_WIDTH{1'b0}}, 1'b1};
  localparam logic [VECTOR_WIDTH:0] WORDS_MAX = {(VECTOR_WIDTH+1){1'b1}};

  logic we_d_r;

  assign rise = vacc_we & ~we_d_r;
  assign fall = ~vacc_we & we_d_r;

  // Strobe history and word count; a new burst restarts the count at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_d_r <= 1'b0;
      words  <= {(VECTOR_WIDTH+1){1'b0}};
    end else if (ce) begin
      we_d_r <= vacc_we;
      if (rise) begin
        words <= WORDS_ONE;
      end else if (vacc_we && (words != WORDS_MAX)) begin
        words <= words + WORDS_ONE;
      end
    end
  end

endmodule

// File: rtl/vacc_sched.sv
// Vector-accumulator sequencer: sync/trig generation, dump tracking and consumer handshake.
// Define VACC_SCHED_TIMEOUT_EN to add the ACCUM watchdog driving timeout_err.
module vacc_sched
  import vacc_sched_pkg::*;
#(
  parameter int VECTOR_WIDTH  = 3,
  parameter int SEQ_WIDTH     = 32,
  parameter int SKIP_WIDTH    = 16,
  parameter int TIMEOUT_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  sync_in,
  input  logic                  arm,
  input  logic                  disarm,
  input  logic                  cont,
  input  logic [SKIP_WIDTH-1:0] cfg_skip,
  input  logic                  vacc_we,
  input  logic                  dump_ack,
  output logic                  vacc_sync,
  output logic                  vacc_trig,
  output logic                  dump_ready,
  output logic [SEQ_WIDTH-1:0]  dump_seq,
  output logic [VECTOR_WIDTH:0] dump_words,
  output logic [OVR_WIDTH-1:0]  overrun_cnt,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam logic [SKIP_WIDTH-1:0] SKIP_ONE = {{(SKIP_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SEQ_WIDTH-1:0]  SEQ_ONE  = {{(SEQ_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_r, state_nxt_s;
  logic                    arm_pend_r, arm_pend_nxt_s;
  logic                    disarm_pend_r, disarm_pend_nxt_s;
  logic                    first_done_r;
  logic [SKIP_WIDTH-1:0]   skip_cnt_r, skip_lat_r;
  logic                    sync_nxt_s, trig_nxt_s, enter_wait_s, inc_skip_s, dump_done_s;
  logic                    rise_s, fall_s, timeout_hit_s;
  logic [VECTOR_WIDTH:0]   words_s;

  vacc_dump_monitor #(.VECTOR_WIDTH(VECTOR_WIDTH)) u_mon (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .vacc_we (vacc_we),
    .rise    (rise_s),
    .fall    (fall_s),
    .words   (words_s)
  );

  // Next-state and pulse decode for the dump sequencer.
  always_comb begin
    state_nxt_s       = state_r;
    sync_nxt_s        = 1'b0;
    trig_nxt_s        = 1'b0;
    enter_wait_s      = 1'b0;
    inc_skip_s        = 1'b0;
    dump_done_s       = 1'b0;
    arm_pend_nxt_s    = arm_pend_r;
    disarm_pend_nxt_s = disarm_pend_r;
    case (state_r)
      ST_IDLE: begin
        disarm_pend_nxt_s = 1'b0;
        if (disarm) begin
          arm_pend_nxt_s = 1'b0;
        end else if ((arm || arm_pend_r) && sync_in) begin
          sync_nxt_s     = 1'b1;
          enter_wait_s   = 1'b1;
          arm_pend_nxt_s = 1'b0;
          state_nxt_s    = ST_WAIT;
        end else if (arm) begin
          arm_pend_nxt_s = 1'b1;
        end else begin
          arm_pend_nxt_s = arm_pend_r;
        end
      end
      ST_WAIT: begin
        if (disarm) begin
          state_nxt_s = ST_IDLE;
        end else if (sync_in) begin
          if (skip_cnt_r == skip_lat_r) begin
            trig_nxt_s  = 1'b1;
            state_nxt_s = ST_ACCUM;
          end else begin
            inc_skip_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_ACCUM: begin
        if (disarm || timeout_hit_s) begin
          state_nxt_s = ST_IDLE;
        end else if (rise_s) begin
          state_nxt_s = ST_DUMP;
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      ST_DUMP: begin
        // A disarm seen mid-burst is remembered so the dump still completes first.
        if (fall_s) begin
          dump_done_s       = 1'b1;
          disarm_pend_nxt_s = 1'b0;
          if (cont && !disarm && !disarm_pend_r) begin
            enter_wait_s = 1'b1;
            state_nxt_s  = ST_WAIT;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else if (disarm) begin
          disarm_pend_nxt_s = 1'b1;
        end else begin
          disarm_pend_nxt_s = disarm_pend_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, registered pulses and the sync skip counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      busy          <= 1'b0;
      vacc_sync     <= 1'b0;
      vacc_trig     <= 1'b0;
      arm_pend_r    <= 1'b0;
      disarm_pend_r <= 1'b0;
      skip_cnt_r    <= {SKIP_WIDTH{1'b0}};
      skip_lat_r    <= {SKIP_WIDTH{1'b0}};
    end else if (ce) begin
      state_r       <= state_nxt_s;
      busy          <= (state_nxt_s != ST_IDLE);
      vacc_sync     <= sync_nxt_s;
      vacc_trig     <= trig_nxt_s;
      arm_pend_r    <= arm_pend_nxt_s;
      disarm_pend_r <= disarm_pend_nxt_s;
      if (enter_wait_s) begin
        skip_cnt_r <= {SKIP_WIDTH{1'b0}};
        skip_lat_r <= cfg_skip;
      end else if (inc_skip_s) begin
        skip_cnt_r <= skip_cnt_r + SKIP_ONE;
      end
    end
  end

  // Dump reporting: ready/ack handshake, sequence number and overrun count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dump_ready   <= 1'b0;
      dump_words   <= {(VECTOR_WIDTH+1){1'b0}};
      dump_seq     <= {SEQ_WIDTH{1'b0}};
      first_done_r <= 1'b0;
      overrun_cnt  <= {OVR_WIDTH{1'b0}};
    end else if (ce) begin
      if (dump_done_s) begin
        dump_ready   <= 1'b1;
        dump_words   <= words_s;
        first_done_r <= 1'b1;
        if (first_done_r) begin
          dump_seq <= dump_seq + SEQ_ONE;
        end
      end else if (dump_ack) begin
        dump_ready <= 1'b0;
      end
      if (rise_s && dump_ready && !dump_ack) begin
        overrun_cnt <= ovr_inc(overrun_cnt);
      end
    end
  end

`ifdef VACC_SCHED_TIMEOUT_EN
  localparam logic [TIMEOUT_WIDTH-1:0] WD_ONE  = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

  logic [TIMEOUT_WIDTH-1:0] wd_cnt_r;

  assign timeout_hit_s = (state_r == ST_ACCUM) && !disarm && !rise_s && (wd_cnt_r == WD_LAST);

  // Watchdog over ce-cycles spent in ACCUM; the error flag is sticky until rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_r    <= {TIMEOUT_WIDTH{1'b0}};
      timeout_err <= 1'b0;
    end else if (ce) begin
      if (state_r == ST_ACCUM) begin
        wd_cnt_r <= wd_cnt_r + WD_ONE;
      end else begin
        wd_cnt_r <= {TIMEOUT_WIDTH{1'b0}};
      end
      if (timeout_hit_s) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout_width_s;

  assign unused_timeout_width_s = (TIMEOUT_WIDTH != 32'sd0);
  assign timeout_hit_s          = 1'b0;
  assign timeout_err            = 1'b0;
`endif

endmodule

// File: tb/tb_vacc_sched.sv
// Self-checking bench for vacc_sched: directed table, corner-case sequences and a randomized
// dump stream checked against a transaction-level model.
module tb_vacc_sched;

  logic        clk = 1'b0;
  logic        rst, ce, sync_in, arm, disarm, cont, vacc_we, dump_ack;
  logic [15:0] cfg_skip;
  logic        vacc_sync, vacc_trig, dump_ready, busy, timeout_err;
  logic [31:0] dump_seq;
  logic [3:0]  dump_words;
  logic [15:0] overrun_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit gap_en   = 1'b0;

  vacc_sched #(
    .VECTOR_WIDTH(3), .SEQ_WIDTH(32), .SKIP_WIDTH(16), .TIMEOUT_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .sync_in(sync_in), .arm(arm), .disarm(disarm),
    .cont(cont), .cfg_skip(cfg_skip), .vacc_we(vacc_we), .dump_ack(dump_ack),
    .vacc_sync(vacc_sync), .vacc_trig(vacc_trig), .dump_ready(dump_ready),
    .dump_seq(dump_seq), .dump_words(dump_words), .overrun_cnt(overrun_cnt),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Directed vector: one ce-cycle of inputs and the outputs expected right after it.
  typedef struct packed {
    logic s, a, d, w, k;
    logic e_sync, e_trig, e_ready, e_busy;
    logic [3:0] e_words;
  } vec_t;
  vec_t tbl [20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic gap();
    ce = 1'b0;
    {sync_in, arm, disarm, vacc_we, dump_ack} = 5'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic cyc(input logic s, input logic a, input logic d, input logic w, input logic k);
    if (gap_en && ($urandom_range(1) == 1)) gap();
    ce = 1'b1; sync_in = s; arm = a; disarm = d; vacc_we = w; dump_ack = k;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    ce = 1'b0;
    {sync_in, arm, disarm, vacc_we, dump_ack} = 5'b00000;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".vacc_sync"}, vacc_sync, 1'b0);
    chk({tag, ".vacc_trig"}, vacc_trig, 1'b0);
    chk({tag, ".dump_ready"}, dump_ready, 1'b0);
    chk({tag, ".dump_seq"}, dump_seq, 32'd0);
    chk({tag, ".dump_words"}, dump_words, 4'd0);
    chk({tag, ".overrun_cnt"}, overrun_cnt, 16'd0);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".timeout_err"}, timeout_err, 1'b0);
  endtask

  task automatic arm_start();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("arm.vacc_sync", vacc_sync, 1'b1);
    chk("arm.busy", busy, 1'b1);
  endtask

  task automatic do_trig(input int skip);
    for (int i = 0; i <= skip; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("trig.sync%0d", i), vacc_trig, (i == skip));
    end
  endtask

  task automatic do_burst(input int len, input logic ack_rise);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, ack_rise);
    repeat (len - 1) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_row(input int i);
    chk($sformatf("tbl%0d.vacc_sync", i), vacc_sync, tbl[i].e_sync);
    chk($sformatf("tbl%0d.vacc_trig", i), vacc_trig, tbl[i].e_trig);
    chk($sformatf("tbl%0d.dump_ready", i), dump_ready, tbl[i].e_ready);
    chk($sformatf("tbl%0d.busy", i), busy, tbl[i].e_busy);
    chk($sformatf("tbl%0d.dump_words", i), dump_words, tbl[i].e_words);
    chk($sformatf("tbl%0d.dump_seq", i), dump_seq, 32'd0);
    chk($sformatf("tbl%0d.overrun_cnt", i), overrun_cnt, 16'd0);
  endtask

  task automatic run_table(input bit toggle);
    do_reset();
    cont = 1'b0;
    cfg_skip = 16'd2;
    chk_all_zero("reset");
    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].w, tbl[i].k);
      check_row(i);
      if (toggle) begin
        gap();
        check_row(i);
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int   skip, nd, mode_prev, len, exp_ovr;
  logic pend, ack_rise;

  initial begin
    rst = 1'b1; ce = 1'b0; cont = 1'b0; cfg_skip = 16'd0;
    {sync_in, arm, disarm, vacc_we, dump_ack} = 5'b00000;

    // columns: s a d w k | sync trig ready busy | words   (cfg_skip=2, cont=0)
    tbl[0]  = {5'b00000, 4'b0000, 4'd0};
    tbl[1]  = {5'b01000, 4'b0000, 4'd0};
    tbl[2]  = {5'b10000, 4'b1001, 4'd0};
    tbl[3]  = {5'b00000, 4'b0001, 4'd0};
    tbl[4]  = {5'b10000, 4'b0001, 4'd0};
    tbl[5]  = {5'b10000, 4'b0001, 4'd0};
    tbl[6]  = {5'b10000, 4'b0101, 4'd0};
    tbl[7]  = {5'b00000, 4'b0001, 4'd0};
    for (int i = 8; i < 15; i++) tbl[i] = {5'b00010, 4'b0001, 4'd0};
    tbl[15] = {5'b00000, 4'b0010, 4'd7};
    tbl[16] = {5'b00000, 4'b0010, 4'd7};
    tbl[17] = {5'b00001, 4'b0000, 4'd7};
    tbl[18] = {5'b00001, 4'b0000, 4'd7};
    tbl[19] = {5'b10000, 4'b0000, 4'd7};

    run_table(1'b0);
    run_table(1'b1);

    // continuous, ack every dump
    gap_en = 1'b1;
    do_reset(); cont = 1'b1; cfg_skip = 16'd0;
    arm_start();
    for (int d = 0; d < 4; d++) begin
      do_trig(0);
      do_burst(3, 1'b0);
      chk("cont_ack.ready", dump_ready, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("cont_ack.cleared", dump_ready, 1'b0);
      chk("cont_ack.busy", busy, 1'b1);
    end
    chk("cont_ack.seq", dump_seq, 32'd3);
    chk("cont_ack.ovr", overrun_cnt, 16'd0);
    chk("cont_ack.words", dump_words, 4'd3);

    // continuous, never ack; then ack coincident with the next rise
    do_reset(); cont = 1'b1; cfg_skip = 16'd0;
    arm_start();
    for (int d = 0; d < 3; d++) begin
      do_trig(0);
      do_burst(2 + d, 1'b0);
    end
    chk("ovr.cnt", overrun_cnt, 16'd2);
    chk("ovr.ready", dump_ready, 1'b1);
    chk("ovr.seq", dump_seq, 32'd2);
    chk("ovr.words", dump_words, 4'd4);
    do_trig(0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("ovr_ack.cnt", overrun_cnt, 16'd2);
    chk("ovr_ack.ready", dump_ready, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr4.ready", dump_ready, 1'b1);
    chk("ovr4.seq", dump_seq, 32'd3);
    chk("ovr4.words", dump_words, 4'd2);
    do_trig(0);
    // asynchronous reset while in ACCUM, away from any clock edge
    #3 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;

    // disarm in WAIT, disarm beats arm
    do_reset(); cont = 1'b0; cfg_skip = 16'd1;
    arm_start();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dis_wait.trig0", vacc_trig, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("dis_wait.busy", busy, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dis_wait.no_trig", vacc_trig, 1'b0);
    chk("dis_wait.no_sync", vacc_sync, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("dis_arm.sync", vacc_sync, 1'b0);
    chk("dis_arm.busy", busy, 1'b0);

    // disarm mid-DUMP: the dump is still reported, then IDLE despite cont=1
    do_reset(); cont = 1'b1; cfg_skip = 16'd0;
    arm_start();
    do_trig(0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("dis_dump.busy_mid", busy, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dis_dump.ready", dump_ready, 1'b1);
    chk("dis_dump.words", dump_words, 4'd3);
    chk("dis_dump.seq", dump_seq, 32'd0);
    chk("dis_dump.busy", busy, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dis_dump.no_trig", vacc_trig, 1'b0);

`ifdef VACC_SCHED_TIMEOUT_EN
    do_reset(); cont = 1'b0; cfg_skip = 16'd0;
    arm_start();
    do_trig(0);
    repeat (14) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("to.err_before", timeout_err, 1'b0);
    chk("to.busy_before", busy, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("to.err", timeout_err, 1'b1);
    chk("to.busy", busy, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("to.sticky", timeout_err, 1'b1);
`else
    do_reset(); cont = 1'b0; cfg_skip = 16'd0;
    arm_start();
    do_trig(0);
    repeat (20) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("no_to.err", timeout_err, 1'b0);
    chk("no_to.busy", busy, 1'b1);
`endif

    // randomized continuous stream against a transaction-level model
    for (int it = 0; it < 20; it++) begin
      do_reset();
      cont = 1'b1;
      skip = $urandom_range(3);
      cfg_skip = 16'(skip);
      if ($urandom_range(1) == 1) begin
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat ($urandom_range(3)) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      chk("rnd.vacc_sync", vacc_sync, 1'b1);
      nd = $urandom_range(5, 1);
      pend = 1'b0;
      exp_ovr = 0;
      mode_prev = 0;
      for (int d = 0; d < nd; d++) begin
        for (int i = 0; i <= skip; i++) begin
          repeat ($urandom_range(2)) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
          cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
          chk($sformatf("rnd%0d.trig%0d", it, i), vacc_trig, (i == skip));
        end
        repeat ($urandom_range(2)) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        len = $urandom_range(8, 1);
        ack_rise = (mode_prev == 2);
        if (pend && !ack_rise) exp_ovr++;
        do_burst(len, ack_rise);
        pend = 1'b1;
        chk($sformatf("rnd%0d.words", it), dump_words, len);
        chk($sformatf("rnd%0d.seq", it), dump_seq, d);
        chk($sformatf("rnd%0d.ready", it), dump_ready, 1'b1);
        chk($sformatf("rnd%0d.ovr", it), overrun_cnt, exp_ovr);
        chk($sformatf("rnd%0d.busy", it), busy, 1'b1);
        mode_prev = $urandom_range(2);
        if (mode_prev == 1) begin
          cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
          pend = 1'b0;
          chk($sformatf("rnd%0d.ack", it), dump_ready, 1'b0);
        end
      end
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("rnd%0d.disarm", it), busy, 1'b0);
    end
    gap_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
